fwd_scoreboard_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard unit for the pipelined RISC-V core.

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_sel_encoder.sv | 32 +++
 rtl/fwd_scoreboard_unit.sv | 103 ++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants, types and helpers for the operand-forwarding / hazard unit.
package fwd_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // Default width of a multi-cycle writeback countdown.
  localparam int SB_LAT_W = 3;

  // Scoreboard countdown counter at the default latency width.
  typedef logic [SB_LAT_W-1:0] sb_cnt_t;

  // Bypass source k is reported on the forward select as k+1.
  function automatic int sel_of_source(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_sel_encoder.sv
// Priority encoder choosing the youngest bypass source that holds a given register.
module fwd_sel_encoder
  import fwd_pkg::*;
#(
  parameter  int ADDR_W  = 5,
  parameter  int NUM_FWD = 2,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [ADDR_W-1:0]         rs,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_regwrite,
  output logic [SEL_W-1:0]          sel
);

  logic [NUM_FWD-1:0] hit;

  // A source matches only if it writes a real register equal to rs; rs==0 can never match.
  for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
    assign hit[gi] = fwd_regwrite[gi]
                  && (fwd_rd[gi*ADDR_W +: ADDR_W] != '0)
                  && (fwd_rd[gi*ADDR_W +: ADDR_W] == rs);
  end

  // Scan oldest to youngest so the lowest matching index is the final winner.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(sel_of_source(k));
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding, multi-cycle writeback scoreboard, ID stall and stall counter.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter  int ADDR_W  = 5,
  parameter  int NUM_FWD = 2,
  parameter  int LAT_W   = SB_LAT_W,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         ex_rs1,
  input  logic [ADDR_W-1:0]         ex_rs2,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_regwrite,
  input  logic [ADDR_W-1:0]         id_rs1,
  input  logic [ADDR_W-1:0]         id_rs2,
  input  logic                      ex_memread,
  input  logic [ADDR_W-1:0]         ex_rd,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic [SEL_W-1:0]          forward_a,
  output logic [SEL_W-1:0]          forward_b,
  output logic                      stall,
  output logic [31:0]               stall_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy;
  logic             load_use;
  logic             sb_hazard;
  logic             issue_accept;
  logic [31:0]      stall_count_q;
  logic [31:0]      stall_count_d;

  fwd_sel_encoder #(.ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_enc_a (
    .rs           (ex_rs1),
    .fwd_rd       (fwd_rd),
    .fwd_regwrite (fwd_regwrite),
    .sel          (sel_a)
  );

  fwd_sel_encoder #(.ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_enc_b (
    .rs           (ex_rs2),
    .fwd_rd       (fwd_rd),
    .fwd_regwrite (fwd_regwrite),
    .sel          (sel_b)
  );

  // Reset forces every combinational output to its idle value.
  always_comb begin
    forward_a    = reset ? SEL_W'(FWD_SEL_RF) : sel_a;
    forward_b    = reset ? SEL_W'(FWD_SEL_RF) : sel_b;
    load_use     = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    sb_hazard    = busy[id_rs1] || busy[id_rs2];
    stall        = !reset && (load_use || sb_hazard);
    issue_accept = issue_valid && !stall && (issue_rd != '0) && (issue_lat != '0);
  end

  // One countdown per register; x0 is hard-wired idle.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    if (gi == 0) begin : g_x0
      assign cnt_d[gi] = '0;
      assign busy[gi]  = 1'b0;
    end else begin : g_reg
      assign busy[gi] = (cnt_q[gi] != '0);

      // Decrement while pending; an accepted issue to this entry reloads it instead.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cnt_q[gi] != '0) cnt_d[gi] = cnt_q[gi] - LAT_W'(1);
        if (issue_accept && (issue_rd == ADDR_W'(gi))) cnt_d[gi] = issue_lat;
      end
    end

    // Countdown register; reset discards any pending writeback.
    always_ff @(posedge clk) begin
      if (reset) cnt_q[gi] <= '0;
      else       cnt_q[gi] <= cnt_d[gi];
    end
  end

  // Stall cycle counter saturates at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit using an expected-value queue.
module tb_fwd_scoreboard_unit;

  localparam int ADDR_W  = 5;
  localparam int NUM_FWD = 2;
  localparam int LAT_W   = 3;
  localparam int SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [ADDR_W-1:0]         ex_rs1, ex_rs2, id_rs1, id_rs2, ex_rd, issue_rd;
  logic [NUM_FWD*ADDR_W-1:0] fwd_rd;
  logic [NUM_FWD-1:0]        fwd_regwrite;
  logic                      ex_memread, issue_valid;
  logic [LAT_W-1:0]          issue_lat;
  logic [SEL_W-1:0]          forward_a, forward_b;
  logic                      stall;
  logic [31:0]               stall_count;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] sc_exp = 32'd0;

  always #5 clk = ~clk;

  fwd_scoreboard_unit #(.ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .fwd_rd       (fwd_rd),
    .fwd_regwrite (fwd_regwrite),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) begin
        $display("chk %s observed=%0h", e.tag, obs);
      end else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Combinational outputs, sampled 1ns after the inputs settle.
  task automatic chk_out(input string tag, input int efa, input int efb, input bit est);
    push({tag, ".fa"}, 32'(efa));
    push({tag, ".fb"}, 32'(efb));
    push({tag, ".stall"}, {31'd0, est});
    #1;
    pop_chk(32'(forward_a));
    pop_chk(32'(forward_b));
    pop_chk({31'd0, stall});
  endtask

  task automatic chk_cnt(input string tag);
    push({tag, ".cnt"}, sc_exp);
    pop_chk(stall_count);
  endtask

  initial begin
    reset = 1'b1; ex_rs1 = '0; ex_rs2 = '0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    fwd_rd = '0; fwd_regwrite = '0; ex_memread = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
    @(negedge clk);
    @(negedge clk);
    // Reset holds outputs idle even with matching forward and load-use inputs.
    fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11; ex_rs1 = 5'd5;
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    chk_out("rst_hold", 0, 0, 0);
    chk_cnt("rst");

    // Test 1: forwarding priority
    @(negedge clk);
    reset = 1'b0; ex_memread = 1'b0; ex_rd = '0; id_rs2 = '0;
    chk_out("t1_young", 1, 0, 0);
    fwd_regwrite = 2'b10;
    chk_out("t1_old", 2, 0, 0);
    fwd_rd = {5'd5, 5'd6}; fwd_regwrite = 2'b11; ex_rs2 = 5'd6;
    chk_out("t1_mix", 2, 1, 0);
    ex_rs1 = 5'd6;
    chk_out("t1_same", 1, 1, 0);

    // Test 2: x0 never forwarded
    @(negedge clk);
    ex_rs1 = '0; ex_rs2 = '0; fwd_rd = '0; fwd_regwrite = 2'b11;
    chk_out("t2_zero", 0, 0, 0);
    chk_cnt("t2");

    // Test 3: load-use
    @(negedge clk);
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    chk_out("t3_lu", 0, 0, 1); sc_exp++;
    @(negedge clk);
    chk_cnt("t3");
    ex_rd = '0;
    chk_out("t3_x0", 0, 0, 0);

    // Test 4: multi-cycle writeback rd=9 lat=3
    @(negedge clk);
    ex_memread = 1'b0; id_rs2 = '0;
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
    chk_out("t4_issue", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b0; id_rs1 = 5'd9;
    chk_out("t4_b1", 0, 0, 1); sc_exp++;
    @(negedge clk);
    chk_out("t4_b2", 0, 0, 1); sc_exp++;
    @(negedge clk);
    chk_out("t4_b3", 0, 0, 1); sc_exp++;
    @(negedge clk);
    chk_out("t4_clr", 0, 0, 0);
    chk_cnt("t4");

    // Test 5: reload of a busy entry, then issue attempts that must be ignored
    @(negedge clk);
    id_rs1 = '0; issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
    chk_out("t5_i1", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b0;
    chk_out("t5_w1", 0, 0, 0);
    @(negedge clk);
    chk_out("t5_w2", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd4;
    chk_out("t5_re", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_valid = 1'b0; id_rs1 = 5'd9;
      chk_out($sformatf("t5_rb%0d", i), 0, 0, 1); sc_exp++;
    end
    @(negedge clk);
    chk_out("t5_rclr", 0, 0, 0);
    @(negedge clk);
    id_rs1 = 5'd7; ex_memread = 1'b1; ex_rd = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd12; issue_lat = 3'd2;
    chk_out("t5_blk", 0, 0, 1); sc_exp++;
    @(negedge clk);
    ex_memread = 1'b0; ex_rd = '0; issue_valid = 1'b0; id_rs1 = 5'd12;
    chk_out("t5_x12a", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd10; issue_lat = 3'd0;
    chk_out("t5_x12b", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b0; id_rs1 = 5'd10;
    chk_out("t5_lat0", 0, 0, 0);
    chk_cnt("t5");

    // Test 6: reset mid-countdown
    @(negedge clk);
    id_rs1 = '0; issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd5;
    chk_out("t6_i", 0, 0, 0);
    @(negedge clk);
    issue_valid = 1'b0; id_rs1 = 5'd9;
    chk_out("t6_b", 0, 0, 1); sc_exp++;
    @(negedge clk);
    reset = 1'b1;
    chk_out("t6_rst", 0, 0, 0);
    @(negedge clk);
    sc_exp = 32'd0;
    chk_cnt("t6_rst");
    reset = 1'b0;
    chk_out("t6_post", 0, 0, 0);
    @(negedge clk);
    chk_out("t6_post2", 0, 0, 0);
    chk_cnt("t6_post");

    // Saturation: preload the counter near the top and keep stalling
    @(negedge clk);
    force dut.stall_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count_q;
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    chk_out("sat_s", 0, 0, 1);
    @(negedge clk);
    sc_exp = 32'hFFFF_FFFE;
    chk_cnt("sat_fe");
    @(negedge clk);
    sc_exp = 32'hFFFF_FFFF;
    chk_cnt("sat_ff");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_cnt("sat_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
